// File: rtl/seq_stream_checker.sv
// Sequence checker for an incrementing word stream: counts in-order words and mismatches, flags stalls.
// Optional build macro SEQ_STREAM_CHECKER_FIRST_VAL_EN requires the first word in IDLE to equal FIRST_VAL.
module seq_stream_checker #(
    parameter int             W         = 32,
    parameter int             CNT_W     = 16,
    parameter int             TIMEOUT   = 8,
    parameter logic [W-1:0]   FIRST_VAL = W'(32'hcafedeca)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     data_in,
    input  logic             data_vld,
    input  logic             clr,
    output logic             locked,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_pulse,
    output logic [W-1:0]     err_data,
    output logic [W-1:0]     err_exp,
    output logic             stall
);

`ifdef SEQ_STREAM_CHECKER_FIRST_VAL_EN
    localparam bit FirstChk = 1'b1;
`else
    localparam bit FirstChk = 1'b0;
`endif

    localparam int IDLE_W = 8;

    typedef enum logic {IDLE, TRACK} state_t;

    state_t             state_q;
    logic [W-1:0]       exp_q;
    logic [W-1:0]       err_data_q;
    logic [W-1:0]       err_exp_q;
    logic [CNT_W-1:0]   word_cnt_q;
    logic [CNT_W-1:0]   err_cnt_q;
    logic [IDLE_W-1:0]  idle_q;
    logic               err_pulse_q;
    logic               stall_q;

    logic [W-1:0]       base_d;
    logic [W-1:0]       exp_inc_d;
    logic               first_bad_d;
    logic               timeout_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign base_d      = data_in + W'(1);
    assign exp_inc_d   = exp_q + W'(1);
    assign first_bad_d = FirstChk && (data_in != FIRST_VAL);
    assign timeout_d   = (idle_q == IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            err_data_q  <= '0;
            err_exp_q   <= '0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
            idle_q      <= '0;
            err_pulse_q <= 1'b0;
            stall_q     <= 1'b0;
        end else if (clr) begin
            state_q     <= IDLE;
            exp_q       <= '0;
            err_data_q  <= '0;
            err_exp_q   <= '0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
            idle_q      <= '0;
            err_pulse_q <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            err_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (data_vld) begin
                        exp_q   <= base_d;
                        idle_q  <= '0;
                        state_q <= TRACK;
                        if (first_bad_d) begin
                            err_cnt_q   <= sat_inc(err_cnt_q);
                            err_pulse_q <= 1'b1;
                            err_data_q  <= data_in;
                            err_exp_q   <= FIRST_VAL;
                        end else begin
                            word_cnt_q <= sat_inc(word_cnt_q);
                        end
                    end
                end
                TRACK: begin
                    // A valid word always beats the idle timeout in the same cycle.
                    if (data_vld) begin
                        idle_q <= '0;
                        if (data_in == exp_q) begin
                            word_cnt_q <= sat_inc(word_cnt_q);
                            exp_q      <= exp_inc_d;
                        end else begin
                            err_cnt_q   <= sat_inc(err_cnt_q);
                            err_pulse_q <= 1'b1;
                            err_data_q  <= data_in;
                            err_exp_q   <= exp_q;
                            exp_q       <= base_d;
                        end
                    end else if (timeout_d) begin
                        stall_q <= 1'b1;
                        idle_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        idle_q <= idle_q + IDLE_W'(1);
                    end
                end
            endcase
        end
    end

    assign locked    = (state_q == TRACK);
    assign word_cnt  = word_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign err_pulse = err_pulse_q;
    assign err_data  = err_data_q;
    assign err_exp   = err_exp_q;
    assign stall     = stall_q;

endmodule

// File: tb/tb_seq_stream_checker.sv
// Directed bench for seq_stream_checker; expectations adapt when SEQ_STREAM_CHECKER_FIRST_VAL_EN is defined.
module tb_seq_stream_checker;

    localparam int W       = 32;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 8;
`ifdef SEQ_STREAM_CHECKER_FIRST_VAL_EN
    localparam int FE = 1;
`else
    localparam int FE = 0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             data_vld;
    logic [W-1:0]     data_in;
    logic             locked;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             err_pulse;
    logic [W-1:0]     err_data;
    logic [W-1:0]     err_exp;
    logic             stall;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_stream_checker #(
        .W(W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .FIRST_VAL(32'hcafedeca)
    ) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_vld(data_vld), .clr(clr),
        .locked(locked), .word_cnt(word_cnt), .err_cnt(err_cnt), .err_pulse(err_pulse),
        .err_data(err_data), .err_exp(err_exp), .stall(stall)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int w, input int e);
        chk({tag, ".word_cnt"}, 32'(word_cnt), 32'(w));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(e));
    endtask

    // Apply inputs after a falling edge; outputs are observed at the next falling edge.
    task automatic cyc(input logic v, input logic [W-1:0] d);
        data_vld = v;
        data_in  = d;
        @(negedge clk);
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        cyc(1'b0, '0);
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; data_vld = 1'b0; data_in = '0;
        @(negedge clk);
        chk_cnt("reset", 0, 0);
        chk("reset.locked", 32'(locked), 0);
        chk("reset.stall", 32'(stall), 0);
        chk("reset.err_pulse", 32'(err_pulse), 0);
        chk("reset.err_data", err_data, 0);
        rst = 1'b0;

        // Ten in-order words starting at the required first value
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'hcafedeca + W'(i));
            if (i == 0) begin
                chk("seq.first_locked", 32'(locked), 1);
                chk("seq.first_word", 32'(word_cnt), 1);
            end
        end
        data_vld = 1'b0;
        chk_cnt("seq10", 10, 0);
        chk("seq10.locked", 32'(locked), 1);
        chk("seq10.stall", 32'(stall), 0);

        clr_pulse();
        chk_cnt("clr", 0, 0);
        chk("clr.locked", 32'(locked), 0);

        // Modulo wrap
        cyc(1'b1, 32'hFFFFFFFE);
        cyc(1'b1, 32'hFFFFFFFF);
        cyc(1'b1, 32'h00000000);
        cyc(1'b1, 32'h00000001);
        chk_cnt("wrap", 4 - FE, FE);
        clr_pulse();

        // Mismatch and resync
        cyc(1'b1, 32'h10);
        cyc(1'b1, 32'h11);
        cyc(1'b1, 32'h20);
        chk("mis.err_pulse", 32'(err_pulse), 1);
        chk("mis.err_cnt", 32'(err_cnt), 32'(1 + FE));
        chk("mis.err_data", err_data, 32'h20);
        chk("mis.err_exp", err_exp, 32'h12);
        cyc(1'b1, 32'h21);
        chk("mis.pulse_drop", 32'(err_pulse), 0);
        chk_cnt("mis.resync", 3 - FE, 1 + FE);
        clr_pulse();

        // Idle gaps: word on the timeout cycle wins, then a full timeout stalls
        cyc(1'b1, 32'h5);
        repeat (7) cyc(1'b0, '0);
        chk("gap7.locked", 32'(locked), 1);
        chk("gap7.stall", 32'(stall), 0);
        cyc(1'b1, 32'h6);
        chk("wins.word_cnt", 32'(word_cnt), 32'(2 - FE));
        chk("wins.stall", 32'(stall), 0);
        chk("wins.locked", 32'(locked), 1);
        repeat (7) cyc(1'b0, '0);
        chk("gap7b.locked", 32'(locked), 1);
        chk("gap7b.stall", 32'(stall), 0);
        cyc(1'b0, '0);
        chk("timeout.stall", 32'(stall), 1);
        chk("timeout.locked", 32'(locked), 0);
        cyc(1'b1, 32'h100);
        chk("rebase.locked", 32'(locked), 1);
        chk_cnt("rebase", 3 - 2 * FE, 2 * FE);
        chk("rebase.stall_sticky", 32'(stall), 1);
        clr_pulse();
        chk("clr.stall", 32'(stall), 0);

        // Asynchronous reset between clock edges
        cyc(1'b1, 32'h40);
        cyc(1'b1, 32'h50);
        chk("pre_rst.err_pulse", 32'(err_pulse), 1);
        data_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_cnt("async_rst", 0, 0);
        chk("async_rst.locked", 32'(locked), 0);
        chk("async_rst.err_pulse", 32'(err_pulse), 0);
        chk("async_rst.err_data", err_data, 0);
        chk("async_rst.err_exp", err_exp, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        cyc(1'b1, 32'h777);
        chk("post_rst.locked", 32'(locked), 1);
        chk_cnt("post_rst", 1 - FE, FE);

        // clr beats a valid word in the same cycle
        clr = 1'b1;
        cyc(1'b1, 32'h778);
        clr = 1'b0;
        chk_cnt("clr_vld", 0, 0);
        chk("clr_vld.locked", 32'(locked), 0);
        cyc(1'b1, 32'h999);
        chk_cnt("after_clr", 1 - FE, FE);
        chk("after_clr.locked", 32'(locked), 1);

`ifdef SEQ_STREAM_CHECKER_FIRST_VAL_EN
        clr_pulse();
        cyc(1'b1, 32'h12345678);
        chk_cnt("first_bad", 0, 1);
        chk("first_bad.err_exp", err_exp, 32'hcafedeca);
        chk("first_bad.err_data", err_data, 32'h12345678);
        chk("first_bad.locked", 32'(locked), 1);
        chk("first_bad.err_pulse", 32'(err_pulse), 1);
        cyc(1'b1, 32'h12345679);
        chk_cnt("first_follow", 1, 1);
        chk("first_follow.err_pulse", 32'(err_pulse), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_stream_checker.md
Name: seq_stream_checker

Overview:
- Downstream consumer of the 32-bit word stream driven onto the bus interface by the driver clocking block.
- Samples each valid word and checks that it is the previous word plus one, modulo 2^W.
- Keeps match, error and stall statistics in hardware so monitor/scoreboard code can read pass/fail state directly instead of parsing log output.

Parameters:
- W, 32, data word width in bits.
- CNT_W, 16, width of word_cnt and err_cnt; both saturate at all-ones.
- TIMEOUT, 8, number of consecutive idle cycles in TRACK that triggers a stall, range 1..255.
- FIRST_VAL, 32'hcafedeca, required first word; used only when SEQ_STREAM_CHECKER_FIRST_VAL_EN is defined.

Ports:
- clk  input  1  rising-edge clock, shared with the bus interface.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  W  sampled stream word.
- data_vld  input  1  data_in is valid this cycle.
- clr  input  1  synchronous clear: zeroes both counters and sticky flags, forces IDLE.
- locked  output  1  checker is in TRACK.
- word_cnt  output  CNT_W  number of in-sequence words accepted.
- err_cnt  output  CNT_W  number of sequence mismatches.
- err_pulse  output  1  one-cycle pulse, asserted the cycle after a mismatch.
- err_data  output  W  received word of the most recent mismatch.
- err_exp  output  W  expected word of the most recent mismatch.
- stall  output  1  sticky flag: TIMEOUT expired while in TRACK.

Behaviour:
- Reset (async, rst=1): state=IDLE, expected=0, all outputs 0, idle counter=0.
- All other updates happen on posedge clk. All outputs are registered, so the response appears the cycle after the sampled input.
- clr has priority over every other event in the same cycle. It has the same effect as reset except it is synchronous.
- States: IDLE, TRACK.
- IDLE:
  - data_vld=1: expected <= data_in+1, word_cnt++, go to TRACK.
  - data_vld=0: stay in IDLE; no counting.
- TRACK:
  - data_vld=1 and data_in==expected: word_cnt++, expected <= expected+1, idle counter <= 0.
  - data_vld=1 and data_in!=expected: err_cnt++, err_pulse=1 next cycle, err_data<=data_in, err_exp<=expected. Resync with expected <= data_in+1 and stay in TRACK.
  - data_vld=0: idle counter++. When it reaches TIMEOUT: stall<=1, go to IDLE, idle counter <= 0.
  - data_vld=1 in the cycle the idle counter would reach TIMEOUT: the word wins. It is processed normally and no stall is raised.
- Arithmetic:
  - expected increments modulo 2^W, so 0xFFFFFFFF followed by 0x00000000 is a match.
  - word_cnt and err_cnt hold at 2^CNT_W-1 and never wrap.
- locked = (state==TRACK).
- Reset asserted mid-stream clears everything immediately, without waiting for a clock edge. The first valid word after reset is treated as a new base.
- A word whose value equals expected is accepted whether or not it follows an idle gap.

Optional Feature:
- Macro: SEQ_STREAM_CHECKER_FIRST_VAL_EN.
- When defined, the first word seen in IDLE must equal FIRST_VAL:
  - Equal: accepted exactly as in the base behaviour.
  - Not equal: counted as a mismatch (err_exp=FIRST_VAL). The checker still goes to TRACK with expected <= data_in+1.
- When not defined: the first word in IDLE is captured as the base with no check, and the FIRST_VAL parameter is ignored.

Test Plan:
- Send 10 consecutive valid words 0xcafedeca..0xcafeded3 after reset -> word_cnt=10, err_cnt=0, locked=1 from the cycle after the first word, stall=0.
- Send 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001 -> word_cnt=4, err_cnt=0 (modulo wrap is accepted).
- Send 0x10, 0x11, 0x20, 0x21 -> err_cnt=1, err_pulse for one cycle after 0x20, err_data=0x20, err_exp=0x12, word_cnt=3.
- Send 0x5, then hold data_vld=0 for 8 cycles (TIMEOUT=8) -> stall=1, locked=0. Then send 0x100 -> locked=1, word_cnt=2, err_cnt=0.
- Assert rst asynchronously mid-stream, between clock edges -> all outputs 0 immediately. Check again with clr=1 and data_vld=1 in the same cycle -> counters 0, state IDLE, the word is ignored.
- With SEQ_STREAM_CHECKER_FIRST_VAL_EN defined, send 0x12345678 first -> err_cnt=1, err_exp=0xcafedeca. Then send 0x12345679 -> word_cnt=1, no new error.
